// File: rtl/dnd_pkg.sv
// Shared DND pipeline types: CAVIAR event layout and default field widths.
package dnd_pkg;

    localparam int DND_XY_BITS = 9;
    localparam int DND_EV_W    = 2 * DND_XY_BITS + 1;
    localparam int DND_SCORE_W = 16;

    // Member order packs to {pol, y, x}, matching the ev_in bit order.
    typedef struct packed {
        logic                   pol;
        logic [DND_XY_BITS-1:0] y;
        logic [DND_XY_BITS-1:0] x;
    } caviar_ev_t;

    function automatic caviar_ev_t make_ev(input logic [DND_XY_BITS-1:0] x,
                                           input logic [DND_XY_BITS-1:0] y,
                                           input logic                   pol);
        caviar_ev_t ev;
        ev.pol = pol;
        ev.y   = y;
        ev.x   = x;
        return ev;
    endfunction

endpackage

// File: rtl/dnd_tag_fifo.sv
// Register-based in-order tag FIFO; a push is accepted while full if a pop happens in the same cycle.
module dnd_tag_fifo
    import dnd_pkg::*;
#(
    parameter int W     = DND_EV_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        full    = (count == DEPTH_C);
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dnd_event_classifier.sv
// Pairs each queued CAVIAR event with its MLP score, flags signal/noise against a threshold,
// and keeps saturating signal/noise statistics plus sticky FIFO error flags.
module dnd_event_classifier
    import dnd_pkg::*;
#(
    parameter int CAVIAR_X_Y_BITS = DND_XY_BITS,
    parameter int W_Y             = DND_SCORE_W,
    parameter int DEPTH           = 4,
    parameter int CNT_W           = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*CAVIAR_X_Y_BITS:0]   ev_in,
    input  logic                         ev_in_vld,
    input  logic [W_Y-1:0]               score,
    input  logic                         score_vld,
    input  logic [W_Y-1:0]               threshold,
    input  logic                         clr_cnt,
    output logic [2*CAVIAR_X_Y_BITS:0]   ev_out,
    output logic                         ev_out_sig,
    output logic                         ev_out_vld,
    output logic                         busy,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic [CNT_W-1:0]             sig_cnt,
    output logic [CNT_W-1:0]             noise_cnt
);

    localparam int EV_W = 2 * CAVIAR_X_Y_BITS + 1;
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EV_W-1:0] head_ev;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop_ok;
    logic            push_drop;
    logic            is_sig;

    dnd_tag_fifo #(
        .W     (EV_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_in_vld),
        .pop   (score_vld),
        .din   (ev_in),
        .dout  (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        pop_ok    = score_vld && !fifo_empty;
        push_drop = ev_in_vld && fifo_full && !pop_ok;
        is_sig    = ($signed(score) >= $signed(threshold));
        busy      = (fifo_count == DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_out     <= '0;
            ev_out_sig <= 1'b0;
            ev_out_vld <= 1'b0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            sig_cnt    <= '0;
            noise_cnt  <= '0;
        end else begin
            ev_out_vld <= pop_ok;
            if (pop_ok) begin
                ev_out     <= head_ev;
                ev_out_sig <= is_sig;
            end

            if (push_drop) ovf_err <= 1'b1;
            if (score_vld && fifo_empty) unf_err <= 1'b1;

            // Clear takes priority over a same-cycle increment.
            if (clr_cnt) begin
                sig_cnt   <= '0;
                noise_cnt <= '0;
            end else if (pop_ok) begin
                if (is_sig) begin
                    if (sig_cnt != '1) sig_cnt <= sig_cnt + 1'b1;
                end else begin
                    if (noise_cnt != '1) noise_cnt <= noise_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnd_event_classifier.sv
// Directed plus randomized bench for dnd_event_classifier against a queue-based reference model.
module tb_dnd_event_classifier;
    import dnd_pkg::*;

    localparam int XY    = 9;
    localparam int EVW   = 2 * XY + 1;
    localparam int WY    = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [EVW-1:0]   ev_in;
    logic             ev_in_vld;
    logic [WY-1:0]    score;
    logic             score_vld;
    logic [WY-1:0]    threshold;
    logic             clr_cnt;
    logic [EVW-1:0]   ev_out;
    logic             ev_out_sig;
    logic             ev_out_vld;
    logic             busy;
    logic             ovf_err;
    logic             unf_err;
    logic [CNTW-1:0]  sig_cnt;
    logic [CNTW-1:0]  noise_cnt;

    dnd_event_classifier #(
        .CAVIAR_X_Y_BITS (XY),
        .W_Y             (WY),
        .DEPTH           (DEPTH),
        .CNT_W           (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_in      (ev_in),
        .ev_in_vld  (ev_in_vld),
        .score      (score),
        .score_vld  (score_vld),
        .threshold  (threshold),
        .clr_cnt    (clr_cnt),
        .ev_out     (ev_out),
        .ev_out_sig (ev_out_sig),
        .ev_out_vld (ev_out_vld),
        .busy       (busy),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
        .sig_cnt    (sig_cnt),
        .noise_cnt  (noise_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [EVW-1:0] m_q [$];
    logic [EVW-1:0] m_ev;
    logic           m_sig;
    logic           m_vld;
    logic           m_ovf;
    logic           m_unf;
    int             m_sc;
    int             m_nc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pop_ok, push_ok, s;
        if (rst) begin
            m_q.delete();
            m_ev = '0; m_sig = 0; m_vld = 0; m_ovf = 0; m_unf = 0; m_sc = 0; m_nc = 0;
            return;
        end
        pop_ok  = score_vld && (m_q.size() > 0);
        push_ok = ev_in_vld && ((m_q.size() < DEPTH) || pop_ok);
        if (ev_in_vld && !push_ok) m_ovf = 1;
        if (score_vld && m_q.size() == 0) m_unf = 1;
        m_vld = pop_ok;
        s = 0;
        if (pop_ok) begin
            s     = (int'($signed(score)) >= int'($signed(threshold)));
            m_ev  = m_q.pop_front();
            m_sig = s;
        end
        if (push_ok) m_q.push_back(ev_in);
        if (clr_cnt) begin
            m_sc = 0; m_nc = 0;
        end else if (pop_ok) begin
            if (s) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            else   m_nc = (m_nc < CMAX) ? m_nc + 1 : CMAX;
        end
    endtask

    task automatic check_all();
        chk("ev_out_vld", 32'(ev_out_vld), 32'(m_vld));
        if (m_vld) begin
            chk("ev_out", 32'(ev_out), 32'(m_ev));
            chk("ev_out_sig", 32'(ev_out_sig), 32'(m_sig));
        end
        chk("busy", 32'(busy), 32'(m_q.size() == DEPTH));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
        chk("sig_cnt", 32'(sig_cnt), 32'(m_sc));
        chk("noise_cnt", 32'(noise_cnt), 32'(m_nc));
    endtask

    task automatic step(input logic iv, input logic [EVW-1:0] ie, input logic sv,
                        input logic [WY-1:0] sc, input logic cl, input logic rs);
        ev_in_vld = iv; ev_in = ie; score_vld = sv; score = sc; clr_cnt = cl; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        logic [EVW-1:0] e1, e2, ea;
        threshold = 16'd100;
        step(0, '0, 0, '0, 0, 1);
        chk("reset_vld", 32'(ev_out_vld), 32'd0);
        chk("reset_sig_cnt", 32'(sig_cnt), 32'd0);

        // Basic order
        e1 = make_ev(9'd5, 9'd7, 1'b1);
        e2 = make_ev(9'd345, 9'd259, 1'b0);
        step(1, e1, 0, '0, 0, 0);
        step(1, e2, 0, '0, 0, 0);
        step(0, '0, 1, 16'd150, 0, 0);
        chk("basic_first_ev", 32'(ev_out), 32'(19'h0_0E05 | (19'd1 << 18)));
        chk("basic_first_sig", 32'(ev_out_sig), 32'd1);
        step(0, '0, 1, 16'd99, 0, 0);
        chk("basic_second_sig", 32'(ev_out_sig), 32'd0);
        chk("basic_cnts", 32'({sig_cnt, noise_cnt}), 32'({4'd1, 4'd1}));

        // Boundary compare
        threshold = -16'sd3;
        step(1, e1, 0, '0, 0, 0);
        step(1, e2, 1, -16'sd3, 0, 0);
        chk("bnd_eq_neg", 32'(ev_out_sig), 32'd1);
        step(1, e1, 1, 16'h8000, 0, 0);
        chk("bnd_min", 32'(ev_out_sig), 32'd0);
        threshold = 16'h7FFF;
        step(0, '0, 1, 16'h7FFF, 0, 0);
        chk("bnd_max_eq", 32'(ev_out_sig), 32'd1);
        idle();

        // Full / overflow / push+pop while full
        threshold = 16'd0;
        for (int i = 0; i < 4; i++) step(1, EVW'(i + 1), 0, '0, 0, 0);
        chk("full_busy", 32'(busy), 32'd1);
        step(1, EVW'(9), 0, '0, 0, 0);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        step(1, EVW'(10), 1, 16'd5, 0, 0);
        chk("full_pushpop_oldest", 32'(ev_out), 32'd1);
        chk("full_pushpop_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 16'd5, 0, 0);

        // Underflow
        step(0, '0, 1, 16'd5, 0, 0);
        chk("unf_set", 32'(unf_err), 32'd1);
        chk("unf_no_vld", 32'(ev_out_vld), 32'd0);
        step(1, EVW'(77), 1, 16'd5, 0, 0);
        step(0, '0, 1, 16'd5, 0, 0);
        chk("unf_retained", 32'(ev_out), 32'd77);

        // Saturation and clear
        step(0, '0, 0, '0, 1, 0);
        step(1, EVW'(100), 0, '0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, EVW'(101 + i), 1, 16'd50, 0, 0);
        chk("sat_sig", 32'(sig_cnt), 32'd15);
        step(0, '0, 1, 16'd50, 1, 0);
        chk("clr_wins", 32'(sig_cnt), 32'd0);
        chk("clr_keeps_err", 32'({ovf_err, unf_err}), 32'd3);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1, EVW'(200 + i), 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 1);
        chk("rst_errs", 32'({ovf_err, unf_err, busy}), 32'd0);
        step(0, '0, 1, 16'd5, 0, 0);
        chk("rst_then_unf", 32'(unf_err), 32'd1);
        ea = make_ev(9'd1, 9'd2, 1'b1);
        step(1, ea, 0, '0, 0, 0);
        step(0, '0, 1, -16'sd1, 0, 0);
        chk("rst_new_pair", 32'({ev_out, ev_out_sig}), 32'({ea, 1'b0}));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) threshold = WY'($urandom);
            step($urandom_range(0, 2) != 0, EVW'($urandom),
                 $urandom_range(0, 2) != 0, WY'($urandom),
                 $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dnd_event_classifier.md
# dnd_event_classifier

- Sits directly downstream of `mlp_serial` in the DND pipeline.
- Receives each CAVIAR event at the moment it enters the activation stage and keeps it in an in-order tag FIFO.
- When the matching MLP score arrives, classifies the event as signal or noise against a programmable threshold and emits the original event with its flag.
- Also maintains saturating signal/noise statistics counters.

## Interface

Parameters:
- `CAVIAR_X_Y_BITS`, 9: x/y coordinate width.
- `W_Y`, 16: MLP score width, two's complement.
- `DEPTH`, 4: tag FIFO depth, power of two, ≥2.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `ev_in` in `2*CAVIAR_X_Y_BITS+1`: CAVIAR event; `[8:0]`=x, `[17:9]`=y, `[18]`=polarity.
- `ev_in_vld` in 1: one-cycle pulse; event entered the activation stage.
- `score` in `W_Y`: MLP output.
- `score_vld` in 1: one-cycle pulse; score valid.
- `threshold` in `W_Y`: signed decision threshold; quasi-static.
- `clr_cnt` in 1: synchronous clear of the statistics counters.
- `ev_out` out `2*CAVIAR_X_Y_BITS+1`: classified event.
- `ev_out_sig` out 1: 1 = signal, 0 = noise.
- `ev_out_vld` out 1: one-cycle pulse.
- `busy` out 1: tag FIFO full; upstream must not issue `ev_in_vld`.
- `ovf_err` out 1: sticky; push attempted while full.
- `unf_err` out 1: sticky; score arrived with no pending tag.
- `sig_cnt` out `CNT_W`: number of signal events.
- `noise_cnt` out `CNT_W`: number of noise events.

## Operation

- **Push:** `ev_in_vld` writes `ev_in` at the FIFO tail.
- **Pop:** `score_vld` pops the head. Scores arrive in event order; there is no reordering.
- **Classification:** `ev_out_sig` = `$signed(score) >= $signed(threshold)`. Equality counts as signal.
- **Output register:** `ev_out` = popped tag. `ev_out_vld` pulses once per successful pop.
- **Full, push without pop:** push dropped, `ovf_err` set, FIFO unchanged.
- **Full, push and pop in the same cycle:** both performed; occupancy stays `DEPTH`; no error.
- **Empty, pop:** score dropped, `unf_err` set, no `ev_out_vld`. A push in the same cycle is still accepted; that score is never matched to the event being pushed.
- **Pointers:** wrap modulo `DEPTH`. Occupancy is held in a `$clog2(DEPTH)+1`-bit counter. `busy` = (occupancy == `DEPTH`).
- **Counters:**
  - On each output pulse, `sig_cnt` or `noise_cnt` increments by 1.
  - Both saturate at all-ones.
  - `clr_cnt` zeroes both; clear wins over a same-cycle increment.
  - `clr_cnt` does not clear `ovf_err`/`unf_err`.
- **Reset:** all of the following go to 0 and pending tags are discarded. Reset mid-stream is legal; any score arriving after reset for a pre-reset event follows the empty-pop rule (`unf_err`).
  - outputs `ev_out`, `ev_out_sig`, `ev_out_vld`, `busy`, `ovf_err`, `unf_err`, `sig_cnt`, `noise_cnt`
  - FIFO pointers and occupancy

## Timing

- `score_vld` in cycle N → `ev_out`/`ev_out_sig`/`ev_out_vld` registered, valid in cycle N+1 for exactly one cycle.
- Counters reflect that event in cycle N+1, in the same cycle as `ev_out_vld`.
- A push in cycle N is poppable from cycle N+1; a pop in N+1 returns that tag if it is the head.
- `busy` is registered-state based: it asserts the cycle after the `DEPTH`-th push and deasserts the cycle after a pop with no push.
- Throughput: one push and one pop per cycle, sustained.
- Sticky errors assert the cycle after the offending event and stay set until `rst`.

## Structure

- **`dnd_pkg`:**
  - `caviar_ev_t` packed struct: `pol`, `y`, `x`, laid out so it packs to the `ev_in` bit order.
  - field-width localparams
  - shared with the event source and `create_mlp_activations`.
- **One sub-module `dnd_tag_fifo`:**
  - register-based FIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`
  - same-cycle push/pop when full
  - no error logic; errors live in the top.
- **Top module:** compare, output register, counters, sticky errors.

## Test plan

- **Basic order:** push events (x=5,y=7,p=1), (x=345,y=259,p=0); threshold=100; scores 150, 99 → two pulses: first event with sig=1, second with sig=0; `sig_cnt`=1, `noise_cnt`=1.
- **Boundary compare:** threshold=-3, score=-3 → sig=1. Score=16'h8000 → sig=0. Threshold=16'h7FFF, score=16'h7FFF → sig=1.
- **Full and overflow:**
  - 4 pushes → `busy`=1.
  - 5th push alone → `ovf_err`=1, occupancy 4.
  - Push+pop in the same cycle while full → no new error; output is the oldest tag; occupancy stays 4.
- **Underflow:**
  - Score when empty → `unf_err`=1, no `ev_out_vld`.
  - Simultaneous push+score when empty → pushed tag is retained and emitted on the next score.
- **Saturation and clear:**
  - `CNT_W`=4: 17 signal events → `sig_cnt`=15.
  - `clr_cnt` in the same cycle as an increment → 0 next cycle.
  - Errors unchanged.
- **Reset mid-operation:**
  - `rst` with 3 pending tags → all outputs 0.
  - A following score → `unf_err`=1.
  - New push/score pair → correct output.
